// File: rtl/bcd_countdown_timer_if.sv
// Control and digit bundle for the mm:ss countdown timer.
// master drives presets and commands, slave returns digits and status.
interface bcd_countdown_timer_if;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output load, load_min, load_sec, start, pause,
        input  min_t, min_u, sec_t, sec_u, running, expired, done
    );

    modport slave (
        input  load, load_min, load_sec, start, pause,
        output min_t, min_u, sec_t, sec_u, running, expired, done
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD mm:ss countdown timer with 1 Hz prescaler,
// borrow chain and load/run/pause/expire control.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 100000000,
    parameter int PW       = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PAUSE   = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [3:0]    mt, mu, st, su;
    logic [3:0]    nmt, nmu, nst, nsu;
    logic          done_q;
    logic          tick;
    logic          zero_now;
    logic          zero_next;

    function automatic logic [3:0] clamp(input logic [3:0] d,
                                         input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign zero_now  = ({mt, mu, st, su} == 16'h0000);
    assign zero_next = ({nmt, nmu, nst, nsu} == 16'h0000);

    // Borrow ripples upward only while the lower digit wraps.
    always_comb begin
        nmt = mt;
        nmu = mu;
        nst = st;
        nsu = su - 4'd1;
        if (su == 4'd0) begin
            nsu = 4'd9;
            nst = st - 4'd1;
            if (st == 4'd0) begin
                nst = 4'd5;
                nmu = mu - 4'd1;
                if (mu == 4'd0) begin
                    nmu = 4'd9;
                    nmt = mt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            presc  <= '0;
            mt     <= 4'd0;
            mu     <= 4'd0;
            st     <= 4'd0;
            su     <= 4'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                mt    <= clamp(bus.load_min[7:4], 4'd9);
                mu    <= clamp(bus.load_min[3:0], 4'd9);
                st    <= clamp(bus.load_sec[7:4], 4'd5);
                su    <= clamp(bus.load_sec[3:0], 4'd9);
                state <= IDLE;
                presc <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.pause && bus.start && !zero_now) begin
                            state <= RUN;
                            presc <= '0;
                        end
                    end
                    RUN: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            mt <= nmt;
                            mu <= nmu;
                            st <= nst;
                            su <= nsu;
                        end
                        // Reaching zero overrides a coincident pause.
                        if (tick && zero_next) begin
                            state  <= EXPIRED;
                            done_q <= 1'b1;
                        end else if (bus.pause) begin
                            state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (!bus.pause && bus.start) state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.min_t   = mt;
    assign bus.min_u   = mu;
    assign bus.sec_t   = st;
    assign bus.sec_u   = su;
    assign bus.running = (state == RUN);
    assign bus.expired = (state == EXPIRED);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with TICK_DIV=4:
// expectations are queued by cycle and checked after each edge.
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   s;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(.TICK_DIV(4), .PW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          at;
    logic [15:0] dig;
    logic        r;
    logic        e;
    logic        d;
  } exp_t;

  typedef struct {
    logic [7:0]  lm;
    logic [7:0]  ls;
    logic [15:0] dig;
  } vec_t;

  exp_t q[$];

  task automatic push(input string name, input int at,
                      input logic [15:0] dig,
                      input logic r, input logic e,
                      input logic d);
    exp_t x;
    int   i;
    x.name = name; x.at = at; x.dig = dig;
    x.r = r; x.e = e; x.d = d;
    i = 0;
    while (i < q.size() && q[i].at <= at) i++;
    q.insert(i, x);
  endtask

  task automatic drive(input logic rs, input logic ld,
                       input logic [7:0] lm,
                       input logic [7:0] ls,
                       input logic stt, input logic pa);
    reset        = rs;
    bus.load     = ld;
    bus.load_min = lm;
    bus.load_sec = ls;
    bus.start    = stt;
    bus.pause    = pa;
    s = cyc + 1;
  endtask

  task automatic fin();
    @(negedge clk);
    reset     = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t        x;
    logic [15:0] g;
    cyc = cyc + 1;
    #1;
    while (q.size() > 0 && q[0].at <= cyc) begin
      x = q.pop_front();
      g = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
      total++;
      if (x.at != cyc || g !== x.dig ||
          bus.running !== x.r ||
          bus.expired !== x.e || bus.done !== x.d) begin
        bad++;
        $display("FAIL %s cyc=%0d got dig=%h run=%b exp=%b done=%b want dig=%h run=%b exp=%b done=%b",
                 x.name, cyc, g, bus.running, bus.expired,
                 bus.done, x.dig, x.r, x.e, x.d);
      end
    end
  end

  vec_t vt[6];

  initial begin
    vt[0] = '{8'hAB, 8'h7C, 16'h9959};
    vt[1] = '{8'h12, 8'h34, 16'h1234};
    vt[2] = '{8'h99, 8'h59, 16'h9959};
    vt[3] = '{8'hF0, 8'h6A, 16'h9059};
    vt[4] = '{8'h45, 8'h09, 16'h4509};
    vt[5] = '{8'h00, 8'h00, 16'h0000};

    reset = 1'b1;
    bus.load = 1'b0; bus.load_min = '0; bus.load_sec = '0;
    bus.start = 1'b0; bus.pause = 1'b0;
    @(negedge clk);

    drive(1, 0, 8'h00, 8'h00, 0, 0);
    push("reset", s, 16'h0000, 0, 0, 0);
    fin();

    drive(0, 1, 8'h01, 8'h00, 0, 0);
    push("load0100", s, 16'h0100, 0, 0, 0);
    fin();
    total++;
    if ({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u} !== 16'h0100 ||
        bus.running !== 1'b0) begin
      bad++;
      $display("FAIL direct load0100");
    end
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("run_enter", s, 16'h0100, 1, 0, 0);
    push("pre_tick", s + 3, 16'h0100, 1, 0, 0);
    push("tick0059", s + 4, 16'h0059, 1, 0, 0);
    push("tick0058", s + 8, 16'h0058, 1, 0, 0);
    fin();
    total++;
    if (bus.running !== 1'b1) begin
      bad++;
      $display("FAIL direct run_enter");
    end
    idle(8);

    drive(0, 1, 8'h00, 8'h02, 0, 0);
    push("load0002", s, 16'h0002, 0, 0, 0);
    fin();
    total++;
    if ({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u} !== 16'h0002) begin
      bad++;
      $display("FAIL direct load0002");
    end
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("cd_run", s, 16'h0002, 1, 0, 0);
    push("cd_0001", s + 4, 16'h0001, 1, 0, 0);
    push("cd_pre0", s + 7, 16'h0001, 1, 0, 0);
    push("cd_done", s + 8, 16'h0000, 0, 1, 1);
    push("cd_done_off", s + 9, 16'h0000, 0, 1, 0);
    push("cd_exp_hold", s + 10, 16'h0000, 0, 1, 0);
    fin(); idle(10);
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("exp_start_ign", s, 16'h0000, 0, 1, 0);
    push("exp_start_ign4", s + 4, 16'h0000, 0, 1, 0);
    fin(); idle(4);

    drive(0, 1, 8'h10, 8'h00, 0, 0);
    push("load1000", s, 16'h1000, 0, 0, 0);
    fin();
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("borrow_pre", s + 3, 16'h1000, 1, 0, 0);
    push("borrow_0959", s + 4, 16'h0959, 1, 0, 0);
    fin(); idle(4);

    drive(0, 1, 8'h00, 8'h05, 0, 0);
    push("load0005", s, 16'h0005, 0, 0, 0);
    fin();
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("p_run", s, 16'h0005, 1, 0, 0);
    fin(); idle(1);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    push("paused", s, 16'h0005, 0, 0, 0);
    push("paused20", s + 20, 16'h0005, 0, 0, 0);
    fin(); idle(20);
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("resume", s, 16'h0005, 1, 0, 0);
    push("resume1", s + 1, 16'h0005, 1, 0, 0);
    push("resume_0004", s + 2, 16'h0004, 1, 0, 0);
    fin(); idle(2);

    for (int i = 0; i < 6; i++) begin
      drive(0, 1, vt[i].lm, vt[i].ls, 0, 0);
      push($sformatf("clamp%0d", i), s, vt[i].dig, 0, 0, 0);
      fin();
      total++;
      if ({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u} !== vt[i].dig) begin
        bad++;
        $display("FAIL direct clamp%0d", i);
      end
    end
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    push("zero_start", s, 16'h0000, 0, 0, 0);
    push("zero_start4", s + 4, 16'h0000, 0, 0, 0);
    fin(); idle(4);

    drive(0, 1, 8'h00, 8'h02, 0, 0);
    fin();
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    fin(); idle(3);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    push("tick_pause", s, 16'h0001, 0, 0, 0);
    push("tick_pause2", s + 2, 16'h0001, 0, 0, 0);
    fin(); idle(2);

    drive(0, 1, 8'h00, 8'h01, 0, 0);
    fin();
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    fin(); idle(3);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    push("tick_pause_exp", s, 16'h0000, 0, 1, 1);
    push("tick_pause_exp1", s + 1, 16'h0000, 0, 1, 0);
    fin(); idle(1);

    drive(0, 1, 8'h00, 8'h03, 0, 0);
    fin();
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    fin(); idle(1);
    drive(1, 0, 8'h00, 8'h00, 0, 0);
    push("run_reset", s, 16'h0000, 0, 0, 0);
    push("run_reset4", s + 4, 16'h0000, 0, 0, 0);
    fin();
    total++;
    if ({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u} !== 16'h0000 ||
        bus.running !== 1'b0 || bus.expired !== 1'b0 ||
        bus.done !== 1'b0) begin
      bad++;
      $display("FAIL direct run_reset");
    end
    idle(4);

    drive(0, 1, 8'h00, 8'h03, 0, 0);
    fin();
    drive(0, 0, 8'h00, 8'h00, 1, 0);
    fin(); idle(1);
    drive(0, 1, 8'h12, 8'h34, 0, 0);
    push("run_load", s, 16'h1234, 0, 0, 0);
    push("run_load4", s + 4, 16'h1234, 0, 0, 0);
    fin();
    total++;
    if ({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u} !== 16'h1234 ||
        bus.running !== 1'b0) begin
      bad++;
      $display("FAIL direct run_load");
    end
    idle(4);

    for (int g = 0; g < 50 && q.size() > 0; g++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s never checked (due cyc=%0d, now %0d)",
               x.name, x.at, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
